// File: rtl/uart_rx.sv
// UART receiver: oversampling-free frame decoder driven by an external prescaler's
// mid-bit pulse. Delivers payload bytes on a valid/ready holding register.
module uart_rx #(
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int SyncStages = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rx,
    input  logic                i_half,
    output logic                o_presc_en,
    output logic [DataBits-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_frame_err,
    output logic                o_parity_err,
    output logic                o_overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int              CntW      = 4;
    localparam logic [CntW-1:0] LastBit   = CntW'(DataBits - 1);
    localparam logic            OddParity = (ParityMode == 2);

    logic [SyncStages-1:0] sync_reg;
    logic                  rx_s;
    logic                  rx_q_reg;

    logic [2:0]          state_reg,      state_next;
    logic                presc_en_reg,   presc_en_next;
    logic [CntW-1:0]     bit_cnt_reg,    bit_cnt_next;
    logic [DataBits-1:0] shift_reg,      shift_next;
    logic                parity_bad_reg, parity_bad_next;
    logic [DataBits-1:0] data_reg,       data_next;
    logic                valid_reg,      valid_next;
    logic                frame_err_reg,  frame_err_next;
    logic                parity_err_reg, parity_err_next;
    logic                overrun_reg,    overrun_next;

    logic half;
    logic accept;

    // Line synchroniser: resets to the idle level so no spurious start edge appears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg <= '1;
            rx_q_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], i_rx};
            rx_q_reg <= rx_s;
        end
    end

    assign rx_s   = sync_reg[SyncStages-1];
    assign half   = i_half && presc_en_reg;
    assign accept = valid_reg && i_ready;

    always_comb begin
        state_next      = state_reg;
        presc_en_next   = presc_en_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_bad_next = parity_bad_reg;
        data_next       = data_reg;
        valid_next      = valid_reg;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        overrun_next    = 1'b0;

        if (accept) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (rx_q_reg && !rx_s) begin
                    state_next      = ST_START;
                    presc_en_next   = 1'b1;
                    parity_bad_next = 1'b0;
                end
            end
            ST_START: begin
                if (half) begin
                    if (!rx_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        // Line back high at mid-start: treat as a glitch.
                        state_next    = ST_IDLE;
                        presc_en_next = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (half) begin
                    shift_next   = {rx_s, shift_reg[DataBits-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LastBit) begin
                        state_next = (ParityMode != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (half) begin
                    parity_bad_next = (((^shift_reg) ^ rx_s) != OddParity);
                    state_next      = ST_STOP;
                end
            end
            ST_STOP: begin
                if (half) begin
                    state_next    = ST_IDLE;
                    presc_en_next = 1'b0;
                    if (!rx_s) begin
                        frame_err_next  = 1'b1;
                        parity_err_next = parity_bad_reg;
                    end else if (parity_bad_reg) begin
                        parity_err_next = 1'b1;
                    end else if (valid_reg && !i_ready) begin
                        // Holding register still owned by the consumer: drop the new byte.
                        overrun_next = 1'b1;
                    end else begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                presc_en_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            presc_en_reg   <= 1'b0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_bad_reg <= 1'b0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_en_reg   <= presc_en_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_bad_reg <= parity_bad_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign o_presc_en   = presc_en_reg;
    assign o_data       = data_reg;
    assign o_valid      = valid_reg;
    assign o_frame_err  = frame_err_reg;
    assign o_parity_err = parity_err_reg;
    assign o_overrun    = overrun_reg;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the consumer end of the uart_prescaler bit-timing interface.
- Deserialises an asynchronous 8N1 (optionally parity) line into bytes, delivered on a valid/ready output.
- Enables the prescaler on a detected start edge and samples every bit on the prescaler's mid-bit pulse (o_half → i_half).
- Sits between the pad synchroniser-free rx pin and the UART core FIFO.

Parameters:
- DataBits, 8, payload bits per frame, 5..9, LSB first.
- ParityMode, 0, 0 = none, 1 = even, 2 = odd.
- SyncStages, 2, metastability flops on i_rx, ≥2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx  in  1  asynchronous serial line, idle high.
- i_half  in  1  prescaler mid-bit pulse, one cycle wide; ignored while o_presc_en = 0.
- o_presc_en  out  1  prescaler enable. Prescaler counter is held at 0 when low and restarts on its rising edge.
- o_data  out  DataBits  received payload, stable while o_valid = 1.
- o_valid  out  1  byte available.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_parity_err  out  1  one-cycle pulse: parity mismatch (ParityMode ≠ 0).
- o_overrun  out  1  one-cycle pulse: frame completed while the holding register was still full.

Behaviour:
- Reset (i_rst high at a clock edge):
  - All sync flops = 1.
  - State = IDLE.
  - o_presc_en, o_valid, all error pulses = 0.
  - o_data = 0.
  - Reset mid-frame abandons the frame with no pulses.
- Synchroniser: rx_s = i_rx delayed SyncStages cycles; a history flop rx_q holds the previous rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_q = 1 && rx_s = 0 (falling edge) → START.
  - o_presc_en = 1 from the first cycle in START.
- START, on i_half:
  - rx_s = 0 → DATA, bit_cnt = 0.
  - rx_s = 1 → false start: IDLE, o_presc_en = 0, no pulses.
- DATA, on i_half:
  - shift rx_s into the MSB of the shift register (LSB-first line order); bit_cnt++.
  - After DataBits samples → PARITY if ParityMode ≠ 0, else STOP.
- PARITY, on i_half:
  - Capture rx_s.
  - Error if XOR(data, rx_s) ≠ 0 for even, or ≠ 1 for odd → STOP.
- STOP, on i_half:
  - Sample the stop bit.
  - Next cycle: IDLE, o_presc_en = 0.
  - The edge detector becomes active again in IDLE, so a start bit immediately following the stop bit is caught.
- Completion (the cycle after the stop sample), with accept = o_valid && i_ready:
  - Stop = 1, parity OK, and (!o_valid || i_ready): o_data ← shift register, o_valid = 1.
  - Stop = 1 but o_valid && !i_ready: o_overrun pulses. The old byte is kept and the new byte is dropped.
  - Stop = 0: o_frame_err pulses and no byte is delivered. o_parity_err is also reported if the parity check failed.
  - Parity bad, stop = 1: o_parity_err pulses and no byte is delivered.
- o_valid clears on accept unless a new byte loads in the same cycle. Simultaneous accept + load → o_valid stays 1 with the new data.
- Line glitch shorter than half a bit: rejected in START (false start).
- i_half pulses in IDLE are ignored.
- Edge detection is disabled in all states except IDLE.
- Latency: o_valid rises 1 cycle after the i_half that sampled the stop bit.

Test Plan:
- Byte 0xA5, 8N1, prescaler model Divider = 16 (i_half at count 7), i_ready = 1:
  - o_valid pulses once with o_data = 0xA5.
  - o_valid rises 1 cycle after the 10th i_half.
  - o_presc_en is high from start detect until 1 cycle after that stop i_half.
- Low glitch of 4 cycles on idle line → o_presc_en rises, then falls after the first i_half; no o_valid, no error pulses.
- Frame 0x3C with stop bit forced 0 → o_frame_err single pulse, o_valid stays 0; a following clean frame 0x81 is received correctly.
- i_ready = 0, send 0x11 then 0x22 back-to-back:
  - o_valid = 1, o_data = 0x11 throughout.
  - o_overrun pulses at the end of the second frame.
  - Raising i_ready afterwards clears o_valid.
- ParityMode = 1:
  - Send 0x07 with parity bit 1 → o_data = 0x07, valid.
  - Send 0x07 with parity bit 0 → o_parity_err pulse, no o_valid.
- Assert i_rst during data bit 4 of a frame:
  - Next cycle: o_presc_en = 0, state IDLE, no pulses.
  - After release, frame 0x5A is received intact.
